// File: rtl/reg_dump_unit_pkg.sv
// Shared definitions for the register dump unit: the default register-file
// widths and the state encoding used by the dump sequencer.
package reg_dump_unit_pkg;

    // Default widths, matching the CPU register file this block reads.
    localparam int DEF_ADDR = 5;
    localparam int DEF_SIZE = 32;

    // Sequencer state encoding. Kept as plain constants so existing code that
    // decodes the 2-bit state value keeps working.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/reg_dump_unit_if.sv
// Valid/ready word stream carrying one dumped register (index plus value)
// from the dump unit to its consumer (debug UART, display driver).
interface reg_dump_unit_if
    import reg_dump_unit_pkg::*;
#(
    parameter int ADDR = DEF_ADDR,
    parameter int SIZE = DEF_SIZE
);

    logic            Out_Valid;
    logic            Out_Ready;
    logic [ADDR-1:0] Out_Addr;
    logic [SIZE-1:0] Out_Data;

    // Producer side: the dump unit.
    modport master (
        output Out_Valid,
        output Out_Addr,
        output Out_Data,
        input  Out_Ready
    );

    // Consumer side.
    modport slave (
        input  Out_Valid,
        input  Out_Addr,
        input  Out_Data,
        output Out_Ready
    );

endinterface

// File: rtl/reg_dump_unit.sv
// Register dump unit: on Start, walks the register file read port from
// index 0 to NUMB-1 and emits each captured word with its index over a
// valid/ready stream. Optionally suppresses registers that read zero.
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int ADDR = DEF_ADDR,
    parameter int NUMB = 1 << ADDR,
    parameter int SIZE = DEF_SIZE
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            Start,
    input  logic            Skip_Zero,
    output logic [ADDR-1:0] Rd_Addr,
    input  logic [SIZE-1:0] Rd_Data,
    reg_dump_unit_if.master out_if,
    output logic            Busy,
    output logic            Done,
    output logic [ADDR:0]   Sent_Cnt
);

    // Last register index; the scan ends by comparing against this, so
    // Rd_Addr never has to overflow to signal the end of a dump.
    localparam logic [ADDR-1:0] LAST = ADDR'(NUMB - 1);

    logic [1:0] state;
    logic       skip_q;   // Skip_Zero as captured at Start

    // Sequencer: state, read address counter and all registered outputs.
    // NOTE: every flop here is written with <= so that all branches see the
    // pre-edge values of state, Rd_Addr and Out_Addr regardless of order.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state           <= IDLE;
            Rd_Addr         <= '0;
            out_if.Out_Valid <= 1'b0;
            out_if.Out_Addr  <= '0;
            out_if.Out_Data  <= '0;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            Sent_Cnt        <= '0;
            skip_q          <= 1'b0;
        end else begin
            // NOTE: Done defaults low every cycle so it can only ever be a
            // single-cycle pulse on entry to DONE.
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state    <= FETCH;
                        Rd_Addr  <= '0;
                        skip_q   <= Skip_Zero;
                        Sent_Cnt <= '0;
                        Busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    // Read data is stable here because the register file
                    // writes on the opposite edge.
                    out_if.Out_Data <= Rd_Data;
                    out_if.Out_Addr <= Rd_Addr;
                    if (skip_q && (Rd_Data == '0)) begin
                        if (Rd_Addr == LAST) begin
                            state <= DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            Rd_Addr <= Rd_Addr + 1'b1;
                        end
                    end else begin
                        out_if.Out_Valid <= 1'b1;
                        state            <= SEND;
                    end
                end
                SEND: begin
                    // Word and index stay frozen until the consumer takes it.
                    if (out_if.Out_Ready) begin
                        out_if.Out_Valid <= 1'b0;
                        Sent_Cnt         <= Sent_Cnt + 1'b1;
                        if (out_if.Out_Addr == LAST) begin
                            state <= DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            Rd_Addr <= Rd_Addr + 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Sequential reader for the CPU register file.
- On a Start pulse it drives the register file's read address from 0 to NUMB-1 and captures each read word.
- Each captured word goes out with its index over a valid/ready stream, for a debug UART or display.
- Sits beside the register file and uses one of its combinational read ports; it never writes registers.

Parameters:
- ADDR, 5, register address width.
- NUMB, 1<<ADDR, number of registers scanned.
- SIZE, 32, register data width.

Ports:
- Clk  input  1  clock; all state updates on posedge (the register file writes on negedge, so read data is stable at posedge).
- Clr  input  1  reset, asynchronous, active-high.
- Start  input  1  begin a dump; sampled only in IDLE.
- Skip_Zero  input  1  when 1, registers reading 0 are not emitted; captured at Start.
- Rd_Addr  output  ADDR  read address to the register file port.
- Rd_Data  input  SIZE  combinational read data from the register file port.
- Out_Valid  output  1  Out_Addr/Out_Data hold a word.
- Out_Ready  input  1  consumer accepts the word when Out_Valid&&Out_Ready at posedge.
- Out_Addr  output  ADDR  register index of the emitted word.
- Out_Data  output  SIZE  register value.
- Busy  output  1  high in FETCH/SEND.
- Done  output  1  one-cycle pulse when a dump completes.
- Sent_Cnt  output  ADDR+1  number of words accepted in the current or last dump.

Behaviour:
- Reset (Clr=1, async): state=IDLE. Rd_Addr=0, Out_Valid=0, Out_Addr=0, Out_Data=0, Busy=0, Done=0, Sent_Cnt=0, skip flag=0. Clr mid-dump aborts immediately; no Done is issued.
- States:
  - IDLE → FETCH on Start=1. Rd_Addr=0, skip flag<=Skip_Zero, Sent_Cnt<=0.
  - FETCH: at posedge, Out_Data<=Rd_Data and Out_Addr<=Rd_Addr.
    - If skip flag && Rd_Data==0: the word is skipped. If Rd_Addr==NUMB-1 go to DONE, else Rd_Addr+1 and stay in FETCH.
    - Otherwise Out_Valid<=1 and go to SEND.
  - SEND: hold Out_Valid=1. Out_Addr/Out_Data stay stable while Out_Ready=0.
    - On Out_Ready=1: Out_Valid<=0 and Sent_Cnt+1. If Out_Addr==NUMB-1 go to DONE, else Rd_Addr+1 and go to FETCH.
  - DONE: Done=1 for exactly one cycle, then IDLE. Busy=0 in DONE.
- Latency:
  - Start to first Out_Valid: 2 posedges (IDLE→FETCH, FETCH→SEND).
  - Minimum 2 cycles per emitted word.
  - Minimum full dump with Out_Ready tied high: 1+2*NUMB+1 cycles.
  - Each skipped register costs 1 cycle.
- Start is ignored while Busy or in DONE. Start held high re-triggers only once the block is back in IDLE.
- Rd_Addr wrap: never incremented past NUMB-1; the last index is detected by comparison, not by overflow.
- Sent_Cnt is ADDR+1 bits so a full dump reads NUMB (32) without wrap. It holds its value in IDLE until the next Start.
- Register writes during a dump are tolerated. Each word reflects the register value at its FETCH posedge; no snapshot is taken.
- Out_Valid never deasserts without a handshake, except on Clr.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, FETCH=2'd1, SEND=2'd2, DONE=2'd3;
  - the default widths ADDR/SIZE, shared with the register file.
- Single module; no sub-module is natural. Address counter and state register are one always block; outputs are registered.

Test Plan:
- Registers preloaded with value i*4 for i=0..31, Out_Ready=1, Start pulse → 32 words with Out_Addr 0..31 and Out_Data 0,4,...,124. First Out_Valid 2 cycles after Start. Done pulses once, Sent_Cnt=32.
- Same preload, Skip_Zero=1 → register 0 (value 0) is skipped. 31 words emitted with Out_Addr 1..31, Sent_Cnt=31.
- Out_Ready=0 for 5 cycles on word 3 (value 12) → Out_Valid stays 1 and Out_Addr=3/Out_Data=12 are stable for all 5 cycles. Word 4 follows after Out_Ready rises.
- Clr asserted mid-dump at Out_Addr=10 → all outputs return to 0 immediately, no Done. A new Start restarts from Rd_Addr=0.
- Start re-pulsed while Busy → ignored; still exactly 32 words and one Done.
- All registers 0, Skip_Zero=1 → no Out_Valid. Done after 1+32+1 cycles, Sent_Cnt=0.
